// File: rtl/dmem_pkg.sv
// dmem_pkg: shared owner-tag encoding, pointer type and default widths for the data-memory arbiter
package dmem_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int STARVE_LIMIT_DEF = 8;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID, OWN_HOST} owner_e;
    typedef enum logic {PTR_VID, PTR_HOST} ptr_e;
    typedef struct packed {
        owner_e owner;
        logic   we;
    } tag_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, video, host and RAM signals of the data-memory arbiter
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              cpu_req, cpu_we, cpu_stall;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              vid_req, vid_ack, vid_valid;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_rdata;
    logic              host_req, host_we, host_ack, host_valid;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata, host_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr,
               host_req, host_we, host_addr, host_wdata, mem_rdata,
        output cpu_rdata, cpu_stall, vid_ack, vid_valid, vid_rdata,
               host_ack, host_valid, host_rdata, mem_addr, mem_we, mem_wdata
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr,
               host_req, host_we, host_addr, host_wdata, mem_rdata,
        input  cpu_rdata, cpu_stall, vid_ack, vid_valid, vid_rdata,
               host_ack, host_valid, host_rdata, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/dmem_rr_sel.sv
// dmem_rr_sel: round-robin pick between video and host, CPU first
// DMEM_ARB_STARVE_EN adds a starve counter that stalls the CPU for one cycle after STARVE_LIMIT waits.
module dmem_rr_sel
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic vid_req,
    input  logic host_req,
    output logic cpu_stall,
    output logic vid_gnt,
    output logic host_gnt
);
    ptr_e ptr_q, ptr_d;
    logic sec_ok;
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("dmem_rr_sel: STARVE_LIMIT must be at least 1");
    end
`ifdef DMEM_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif
    always_comb begin
`ifdef DMEM_ARB_STARVE_EN
        cpu_stall = cnt_q == CW'(STARVE_LIMIT);
`else
        cpu_stall = 1'b0;
`endif
        sec_ok = !cpu_req || cpu_stall;
        vid_gnt = sec_ok && vid_req && (!host_req || ptr_q == PTR_VID);
        host_gnt = sec_ok && host_req && (!vid_req || ptr_q == PTR_HOST);
        ptr_d = vid_gnt ? PTR_HOST : host_gnt ? PTR_VID : ptr_q;
`ifdef DMEM_ARB_STARVE_EN
        // only consecutive unserved cycles count; any grant or idle clears
        cnt_d = (cpu_stall || vid_gnt || host_gnt || !(vid_req || host_req)) ? '0 : cnt_q + CW'(1);
`endif
    end
`ifdef DMEM_ARB_STARVE_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            ptr_q <= PTR_VID;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
`else
    always_ff @(posedge clk or posedge reset)
        if (reset) ptr_q <= PTR_VID;
        else ptr_q <= ptr_d;
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous RAM port between CPU, video scanner and host port
// Starvation stall of the CPU is enabled by DMEM_ARB_STARVE_EN (inside dmem_rr_sel).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input logic clk,
    input logic reset,
    dmem_arbiter_if.slave bus
);
    logic cpu_stall, vid_gnt, host_gnt, cpu_own;
    tag_t tag_q, tag_d;
    logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d, vid_rd_q, vid_rd_d, host_rd_q, host_rd_d;

    dmem_rr_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (bus.cpu_req && !reset),
        .vid_req  (bus.vid_req && !reset),
        .host_req (bus.host_req && !reset),
        .cpu_stall(cpu_stall),
        .vid_gnt  (vid_gnt),
        .host_gnt (host_gnt)
    );

    always_comb begin
        cpu_own = bus.cpu_req && !cpu_stall && !reset;
        tag_d.owner = cpu_own ? OWN_CPU : vid_gnt ? OWN_VID : host_gnt ? OWN_HOST : OWN_NONE;
        tag_d.we = cpu_own ? bus.cpu_we : host_gnt && bus.host_we;
        bus.mem_addr = ADDR_W'(cpu_own ? bus.cpu_addr : vid_gnt ? bus.vid_addr : host_gnt ? bus.host_addr : '0);
        bus.mem_we = tag_d.we;
        bus.mem_wdata = cpu_own ? bus.cpu_wdata : host_gnt ? bus.host_wdata : '0;
        bus.cpu_stall = cpu_stall;
        bus.vid_ack = vid_gnt;
        bus.host_ack = host_gnt;
        // RAM data lands one cycle after the grant, so the registered tag steers it
        bus.vid_valid = tag_q.owner == OWN_VID && !tag_q.we;
        bus.host_valid = tag_q.owner == OWN_HOST && !tag_q.we;
        vid_rd_d = bus.vid_valid ? bus.mem_rdata : vid_rd_q;
        host_rd_d = bus.host_valid ? bus.mem_rdata : host_rd_q;
        cpu_rd_d = tag_q.owner == OWN_CPU ? bus.mem_rdata : cpu_rd_q;
        bus.vid_rdata = vid_rd_d;
        bus.host_rdata = host_rd_d;
        bus.cpu_rdata = cpu_rd_d;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            tag_q <= '0;
            cpu_rd_q <= '0;
            vid_rd_q <= '0;
            host_rd_q <= '0;
        end else begin
            tag_q <= tag_d;
            cpu_rd_q <= cpu_rd_d;
            vid_rd_q <= vid_rd_d;
            host_rd_q <= host_rd_d;
        end
endmodule
